pio_edge_irq_in: RTL and testbench

//  Parametrised Avalon-MM input PIO: next-generation status-input port for the QSYS fabric.

---
 rtl/pio_edge_irq_in_if.sv | 25 ++
 rtl/pio_edge_irq_in.sv | 134 +++++++++++++
 tb/tb_pio_edge_irq_in.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pio_edge_irq_in_if.sv
// Avalon-MM slave bus bundle for the edge-capturing input PIO.
// Four 32-bit words, registered read data, no wait states.
interface pio_edge_irq_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );
endinterface

// File: rtl/pio_edge_irq_in.sv
// Input PIO: 2-flop synchroniser, optional per-bit debounce, sticky edge capture
// with RW1C clear, maskable level interrupt, 4-word Avalon-MM register file.
module pio_edge_irq_in #(
  parameter int WIDTH           = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  pio_edge_irq_in_if.slave bus,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [31:0] VALID_MASK =
    (WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'd1 << WIDTH) - 32'd1);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;
  logic [WIDTH-1:0] filt_q;
  logic [WIDTH-1:0] filt_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] ev;

  logic [31:0] irq_mask_q;
  logic [31:0] irq_mask_d;
  logic [31:0] edge_cap_q;
  logic [31:0] edge_cap_d;
  logic [31:0] readdata_q;
  logic [31:0] readdata_d;
  logic [31:0] clr;
  logic        wr_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      filt_q <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= in_port;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      prev_q <= filt_q;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign filt_d = s2_q;
    end else begin : g_debounce
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          filt_bit_d;

        // Any sample equal to the accepted value restarts the count.
        always_comb begin
          cnt_d      = '0;
          filt_bit_d = filt_q[gi];
          if (s2_q[gi] != filt_q[gi]) begin
            if (cnt_q == CNT_LAST) begin
              filt_bit_d = s2_q[gi];
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end

        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        assign filt_d[gi] = filt_bit_d;
      end
    end
  endgenerate

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign ev = filt_q & ~prev_q;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign ev = ~filt_q & prev_q;
    end else begin : g_any
      assign ev = filt_q ^ prev_q;
    end
  endgenerate

  assign wr_en = bus.chipselect & ~bus.write_n;

  // Registers are held at 32 bits; bits at or above WIDTH can never become 1.
  always_comb begin
    irq_mask_d = irq_mask_q;
    clr        = '0;
    if (wr_en && (bus.address == 2'd2)) begin
      irq_mask_d = bus.writedata & VALID_MASK;
    end
    if (wr_en && (bus.address == 2'd3)) begin
      clr = bus.writedata & VALID_MASK;
    end
    edge_cap_d = (edge_cap_q & ~clr) | 32'(ev);

    readdata_d = '0;
    case (bus.address)
      2'd0:    readdata_d = 32'(filt_q);
      2'd2:    readdata_d = irq_mask_q;
      2'd3:    readdata_d = edge_cap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      readdata_q <= '0;
    end else begin
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_pio_edge_irq_in.sv
// Directed bench for pio_edge_irq_in: four instances covering rising/falling/any edge
// and a debounced variant, checked with immediate assertions.
module tb_pio_edge_irq_in;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  always #5 clk = ~clk;

  pio_edge_irq_in_if bus_a ();
  pio_edge_irq_in_if bus_b ();
  pio_edge_irq_in_if bus_c ();
  pio_edge_irq_in_if bus_d ();

  logic [1:0] in_a = '0;
  logic [1:0] in_b = '0;
  logic [1:0] in_c = '0;
  logic [1:0] in_d = '0;
  logic irq_a, irq_b, irq_c, irq_d;

  pio_edge_irq_in #(.WIDTH(2), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .in_port(in_a), .irq(irq_a));
  pio_edge_irq_in #(.WIDTH(2), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b), .in_port(in_b), .irq(irq_b));
  pio_edge_irq_in #(.WIDTH(2), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(0)) dut_c (
    .clk(clk), .reset_n(reset_n), .bus(bus_c), .in_port(in_c), .irq(irq_c));
  pio_edge_irq_in #(.WIDTH(2), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(4)) dut_d (
    .clk(clk), .reset_n(reset_n), .bus(bus_d), .in_port(in_d), .irq(irq_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    $display("chk %s obs=%h exp=%h", tag, obs, exp);
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_bus(input int d, input logic [1:0] a, input logic cs,
                           input logic wn, input logic [31:0] wd);
    case (d)
      0: begin bus_a.address = a; bus_a.chipselect = cs; bus_a.write_n = wn; bus_a.writedata = wd; end
      1: begin bus_b.address = a; bus_b.chipselect = cs; bus_b.write_n = wn; bus_b.writedata = wd; end
      2: begin bus_c.address = a; bus_c.chipselect = cs; bus_c.write_n = wn; bus_c.writedata = wd; end
      default: begin bus_d.address = a; bus_d.chipselect = cs; bus_d.write_n = wn; bus_d.writedata = wd; end
    endcase
  endtask

  function automatic logic [31:0] rd(input int d);
    case (d)
      0:       return bus_a.readdata;
      1:       return bus_b.readdata;
      2:       return bus_c.readdata;
      default: return bus_d.readdata;
    endcase
  endfunction

  task automatic bus_wr(input int d, input logic [1:0] a, input logic [31:0] wd);
    drive_bus(d, a, 1'b1, 1'b0, wd);
    tick();
    drive_bus(d, a, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic bus_rd(input int d, input logic [1:0] a, input logic [31:0] exp, input string tag);
    drive_bus(d, a, 1'b0, 1'b1, 32'h0);
    tick();
    chk(tag, rd(d), exp);
  endtask

  initial begin
    for (int d = 0; d < 4; d++) drive_bus(d, 2'd0, 1'b0, 1'b1, 32'h0);

    // Reset state
    repeat (3) tick();
    chk("rst_rd_a", rd(0), 32'h0);
    chk("rst_irq_d", {31'b0, irq_d}, 32'h0);
    reset_n = 1'b1;
    repeat (3) tick();

    // T1: DATA latency, mask 0 keeps irq low
    in_a = 2'b10;
    repeat (3) tick();
    chk("t1_data_k2", rd(0), 32'h0);
    tick();
    chk("t1_data_k3", rd(0), 32'h2);
    chk("t1_irq", {31'b0, irq_a}, 32'h0);
    bus_rd(0, 2'd3, 32'h2, "t1_edgecap");
    bus_rd(0, 2'd1, 32'h0, "t1_reserved");
    bus_wr(0, 2'd3, 32'h3);
    bus_rd(0, 2'd3, 32'h0, "t1_cleared");

    // T2: masked rising edge raises irq; RW1C clears it
    bus_wr(0, 2'd2, 32'h1);
    bus_rd(0, 2'd2, 32'h1, "t2_mask");
    in_a = 2'b11;
    repeat (3) tick();
    chk("t2_irq_k2", {31'b0, irq_a}, 32'h0);
    tick();
    chk("t2_irq_k3", {31'b0, irq_a}, 32'h1);
    bus_rd(0, 2'd3, 32'h1, "t2_edgecap");
    bus_wr(0, 2'd3, 32'h1);
    chk("t2_irq_clr", {31'b0, irq_a}, 32'h0);
    bus_wr(0, 2'd0, 32'hFFFF_FFFF);
    bus_rd(0, 2'd0, 32'h3, "t2_data_ro");
    bus_wr(0, 2'd2, 32'hFFFF_FFFD);
    bus_rd(0, 2'd2, 32'h1, "t2_mask_width");

    // T3: falling-only and any-edge variants
    in_b = 2'b01;
    repeat (6) tick();
    bus_rd(1, 2'd3, 32'h0, "t3_fall_on_rise");
    in_b = 2'b00;
    repeat (6) tick();
    bus_rd(1, 2'd3, 32'h1, "t3_fall_on_fall");
    chk("t3_fall_irq", {31'b0, irq_b}, 32'h0);
    in_c = 2'b01;
    repeat (6) tick();
    bus_rd(2, 2'd3, 32'h1, "t3_any_rise");
    bus_wr(2, 2'd3, 32'h1);
    bus_rd(2, 2'd3, 32'h0, "t3_any_clr");
    in_c = 2'b00;
    repeat (6) tick();
    bus_rd(2, 2'd3, 32'h1, "t3_any_fall");

    // T4: debounce N=4, 3-cycle pulse rejected, 4-cycle pulse accepted
    drive_bus(3, 2'd0, 1'b0, 1'b1, 32'h0);
    in_d = 2'b01;
    repeat (3) tick();
    in_d = 2'b00;
    repeat (12) tick();
    chk("t4_short_data", rd(3), 32'h0);
    bus_rd(3, 2'd3, 32'h0, "t4_short_edge");
    drive_bus(3, 2'd0, 1'b0, 1'b1, 32'h0);
    in_d = 2'b01;
    repeat (4) tick();
    in_d = 2'b00;
    repeat (4) tick();
    chk("t4_long_data", rd(3), 32'h1);
    repeat (12) tick();
    chk("t4_long_back", rd(3), 32'h0);
    bus_rd(3, 2'd3, 32'h1, "t4_long_edge");

    // T5: clear coincides with a new edge, set wins
    in_a = 2'b10;
    repeat (6) tick();
    bus_rd(0, 2'd3, 32'h0, "t5_pre");
    in_a = 2'b11;
    repeat (3) tick();
    bus_wr(0, 2'd3, 32'h1);
    bus_rd(0, 2'd3, 32'h1, "t5_set_wins");
    chk("t5_irq", {31'b0, irq_a}, 32'h1);
    bus_wr(0, 2'd3, 32'h1);
    bus_rd(0, 2'd3, 32'h0, "t5_clr_after");

    // T6: asynchronous reset mid-debounce
    bus_wr(3, 2'd2, 32'h3);
    in_d = 2'b11;
    repeat (15) tick();
    bus_rd(3, 2'd3, 32'h3, "t6_edgecap");
    chk("t6_irq_pre", {31'b0, irq_d}, 32'h1);
    in_d = 2'b00;
    repeat (2) tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_irq_async", {31'b0, irq_d}, 32'h0);
    chk("t6_rd_async", rd(3), 32'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    bus_rd(3, 2'd0, 32'h0, "t6_data");
    bus_rd(3, 2'd2, 32'h0, "t6_mask");
    bus_rd(3, 2'd3, 32'h0, "t6_edgecap_post");
    repeat (8) tick();
    bus_rd(3, 2'd3, 32'h0, "t6_no_late_edge");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
